// File: rtl/mem_responder.sv
// Memory target for the memEn/R_W/MFC handshake with WAIT_STATES programmable wait states.
// One word access per request. MFC stays high until memEn drops. Reset aborts an access that has not yet completed.
module mem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memEn,
  input  logic                  R_W,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  MFC,
  output logic                  busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  rw_q;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  logic                  access;
  logic                  acc_rw;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_data;

  // With zero wait states the access happens on the acceptance edge itself,
  // so the live inputs are used before they have been latched.
  always_comb begin
    access   = 1'b0;
    acc_rw   = rw_q;
    acc_addr = addr_q;
    acc_data = data_q;
    if (state == IDLE) begin
      access   = memEn && (WAIT_INIT == 4'd0);
      acc_rw   = R_W;
      acc_addr = address;
      acc_data = dataIn;
    end else if (state == WAIT) begin
      access = (cnt <= 4'd1);
    end
  end

  assign busy = (state != IDLE);

  // The array has no reset. A write is blocked while reset is high.
  always_ff @(posedge clk) begin
    if (access && !acc_rw && !reset)
      mem[acc_addr] <= acc_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      data_q  <= '0;
      rw_q    <= 1'b0;
      dataOut <= '0;
      MFC     <= 1'b0;
    end else begin
      if (access && acc_rw)
        dataOut <= mem[acc_addr];
      case (state)
        IDLE: begin
          if (memEn) begin
            addr_q <= address;
            data_q <= dataIn;
            rw_q   <= R_W;
            if (access) begin
              MFC   <= 1'b1;
              state <= DONE;
            end else begin
              cnt   <= WAIT_INIT;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (access) begin
            MFC   <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          if (!memEn) begin
            MFC   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with WAIT_STATES=2 (dut) and WAIT_STATES=0 (dut0). Read data is checked through an expected-value queue.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        sel = 1'b0;
  logic        R_W = 1'b0;
  logic [7:0]  address = 8'h00;
  logic [15:0] dataIn = 16'h0000;

  logic [15:0] d2_dout, d0_dout;
  logic        d2_mfc, d0_mfc, d2_busy, d0_busy;
  logic        en2, en0;

  assign en2 = en & ~sel;
  assign en0 = en & sel;

  wire [15:0] dout = sel ? d0_dout : d2_dout;
  wire        mfc  = sel ? d0_mfc  : d2_mfc;
  wire        bsy  = sel ? d0_busy : d2_busy;

  mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset), .memEn(en2), .R_W(R_W), .address(address),
    .dataIn(dataIn), .dataOut(d2_dout), .MFC(d2_mfc), .busy(d2_busy));

  mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .memEn(en0), .R_W(R_W), .address(address),
    .dataIn(dataIn), .dataOut(d0_dout), .MFC(d0_mfc), .busy(d0_busy));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model [2][256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller is positioned at a negedge. On return memEn has been low across exactly one edge.
  task automatic txn(input logic rw, input logic [7:0] a, input logic [15:0] d,
                     input int hold, input logic pert);
    logic [15:0] exp_d;
    logic [15:0] held;
    int n;
    int lat;
    lat = sel ? 0 : 2;
    en = 1'b1; R_W = rw; address = a; dataIn = d;
    if (rw) exp_q.push_back(model[sel][a]);
    else    model[sel][a] = d;
    @(posedge clk);
    @(negedge clk);
    check("busy_after_accept", 32'(bsy), 32'd1);
    if (pert) begin
      address = a ^ 8'h10; dataIn = 16'hFFFF; R_W = ~rw;
    end
    n = 0;
    while (mfc !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(lat));
    if (rw) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        exp_d = exp_q.pop_front();
        check("rdata", 32'(dout), 32'(exp_d));
      end
    end
    held = dout;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_mfc", 32'(mfc), 32'd1);
      check("hold_busy", 32'(bsy), 32'd1);
      check("hold_dout", 32'(dout), 32'(held));
    end
    en = 1'b0;
    @(negedge clk);
    check("mfc_fall", 32'(mfc), 32'd0);
    check("busy_fall", 32'(bsy), 32'd0);
  endtask

  initial begin
    @(negedge clk);
    check("rst_mfc", 32'(d2_mfc), 32'd0);
    check("rst_busy", 32'(d2_busy), 32'd0);
    check("rst_dout", 32'(d2_dout), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic write followed by a read of the same word
    txn(1'b0, 8'h10, 16'hA5C3, 0, 1'b0);
    txn(1'b1, 8'h10, 16'h0000, 0, 1'b0);

    // Hold memEn past MFC on a write whose inputs change, then on a read
    txn(1'b0, 8'h50, 16'h1234, 5, 1'b1);
    txn(1'b1, 8'h50, 16'h0000, 5, 1'b0);

    // Changes to address, dataIn and R_W after acceptance are ignored
    txn(1'b0, 8'h20, 16'h2020, 0, 1'b0);
    txn(1'b0, 8'h30, 16'h3333, 0, 1'b1);
    txn(1'b1, 8'h30, 16'h0000, 0, 1'b0);
    txn(1'b1, 8'h20, 16'h0000, 0, 1'b0);

    // Reset during WAIT aborts the pending write
    txn(1'b0, 8'h40, 16'h1111, 0, 1'b0);
    txn(1'b1, 8'h40, 16'h0000, 0, 1'b0);
    en = 1'b1; R_W = 1'b0; address = 8'h40; dataIn = 16'h2222;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    en = 1'b0;
    #1;
    check("arst_mfc", 32'(d2_mfc), 32'd0);
    check("arst_dout", 32'(d2_dout), 32'd0);
    check("arst_busy", 32'(d2_busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    txn(1'b1, 8'h40, 16'h0000, 0, 1'b0);

    // Back-to-back reads with memEn low for exactly one edge between them
    txn(1'b0, 8'h01, 16'h0101, 0, 1'b0);
    txn(1'b0, 8'h02, 16'h0202, 0, 1'b0);
    txn(1'b1, 8'h01, 16'h0000, 0, 1'b0);
    txn(1'b1, 8'h02, 16'h0000, 0, 1'b0);

    // Zero wait states
    sel = 1'b1;
    @(negedge clk);
    txn(1'b0, 8'hFF, 16'h0F0F, 0, 1'b0);
    txn(1'b1, 8'hFF, 16'h0000, 2, 1'b0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
